hazard_stall_controller: RTL and testbench

- Parametrised successor to the pipeline's combinational load-use detector.
- Sits in ID and drives PC write-enable, IF/ID write-enable, the ID/EX control-zeroing mux select, and the IF/ID flush.
- Adds the following, all held in an FSM plus counters:
  - configurable multi-cycle load-use stalls
  - register-0 and unused-operand filtering
  - stalls on a busy multi-cycle mul/div unit
  - branch-taken flush priority
  - a saturating stall-cycle performance counter

---
 rtl/hazard_stall_controller.sv | 153 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Purpose : ID-stage hazard controller: load-use, mul/div-busy stalls, branch flush, stall counter.
// Latency : outputs combinational from state + inputs (zero-cycle stall); state updates on clk rise.
// Backpr. : stalls by dropping PC_write/IF_ID_write and bubbling ID/EX; branch flush overrides any stall.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_read_ID_EX, rt_ID_EX        load in EX and its destination register
//   rs_IF_ID, rt_IF_ID              source registers of the ID instruction
//   uses_rs_IF_ID, uses_rt_IF_ID    which sources the ID instruction actually reads
//   md_busy, md_dep_IF_ID           mul/div unit busy / ID instruction depends on it
//   branch_taken_EX                 taken branch/jump resolved in EX
//   stat_clr                        synchronous clear of stall_cycles
//   PC_write, IF_ID_write           1 = PC / IF/ID register update
//   mux_ctrl_signal_sel             1 = pass control, 0 = bubble into ID/EX
//   if_id_flush                     1 = clear IF/ID to NOP
//   stall_state                     0 RUN, 1 LD_STALL, 2 MD_WAIT
//   stall_cycles                    saturating count of cycles with PC_write = 0
module hazard_stall_controller #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_ID_EX,
    input  logic [REG_ADDR_W-1:0] rt_ID_EX,
    input  logic [REG_ADDR_W-1:0] rs_IF_ID,
    input  logic [REG_ADDR_W-1:0] rt_IF_ID,
    input  logic                  uses_rs_IF_ID,
    input  logic                  uses_rt_IF_ID,
    input  logic                  md_busy,
    input  logic                  md_dep_IF_ID,
    input  logic                  branch_taken_EX,
    input  logic                  stat_clr,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  mux_ctrl_signal_sel,
    output logic                  if_id_flush,
    output logic [1:0]            stall_state,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    // The detection cycle is the first bubble, so LD_STALL counts the remaining
    // LOAD_USE_STALLS-1 bubbles down from LOAD_USE_STALLS-2 to 0.
    localparam logic [2:0] LD_INIT = (LOAD_USE_STALLS > 1) ? 3'(LOAD_USE_STALLS - 2) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state, state_nxt;
    logic [2:0] bubble_cnt, bubble_cnt_nxt;
    logic       ld_haz, md_haz;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign ld_haz = mem_read_ID_EX && (rt_ID_EX != '0) &&
                    ((uses_rs_IF_ID && (rs_IF_ID == rt_ID_EX)) ||
                     (uses_rt_IF_ID && (rt_IF_ID == rt_ID_EX)));
    assign md_haz = md_busy && md_dep_IF_ID;

    always_comb begin
        state_nxt           = state;
        bubble_cnt_nxt      = bubble_cnt;
        PC_write            = 1'b1;
        IF_ID_write         = 1'b1;
        mux_ctrl_signal_sel = 1'b1;
        if_id_flush         = 1'b0;

        if (branch_taken_EX) begin
            // Wrong-path instructions in IF/ID and ID are discarded; fetch redirects.
            if_id_flush         = 1'b1;
            mux_ctrl_signal_sel = 1'b0;
            state_nxt           = RUN;
            bubble_cnt_nxt      = 3'd0;
        end else begin
            case (state)
                LD_STALL: begin
                    PC_write            = 1'b0;
                    IF_ID_write         = 1'b0;
                    mux_ctrl_signal_sel = 1'b0;
                    if (bubble_cnt == 3'd0) begin
                        state_nxt = RUN;
                    end else begin
                        bubble_cnt_nxt = bubble_cnt - 3'd1;
                    end
                end
                MD_WAIT: begin
                    if (md_busy) begin
                        PC_write            = 1'b0;
                        IF_ID_write         = 1'b0;
                        mux_ctrl_signal_sel = 1'b0;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (ld_haz || md_haz) begin
                        PC_write            = 1'b0;
                        IF_ID_write         = 1'b0;
                        mux_ctrl_signal_sel = 1'b0;
                    end
                    // md_busy is high whenever md_haz is, so a combined hazard
                    // waits out the mul/div unit first; MD_WAIT releases on md_busy low.
                    if (md_haz) begin
                        state_nxt = MD_WAIT;
                    end else if (ld_haz && (LOAD_USE_STALLS > 1)) begin
                        state_nxt      = LD_STALL;
                        bubble_cnt_nxt = LD_INIT;
                    end
                end
                default: begin
                    state_nxt      = RUN;
                    bubble_cnt_nxt = 3'd0;
                end
            endcase
        end

        // Reset forces pass-through regardless of the hazard inputs.
        if (!rst_n) begin
            PC_write            = 1'b1;
            IF_ID_write         = 1'b1;
            mux_ctrl_signal_sel = 1'b1;
            if_id_flush         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            bubble_cnt <= 3'd0;
        end else begin
            state      <= state_nxt;
            bubble_cnt <= bubble_cnt_nxt;
        end
    end

    // Clear has priority over counting; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stat_clr) begin
            stall_cycles <= '0;
        end else if (!PC_write && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign stall_state = state;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read_ID_EX;
    logic [4:0] rt_ID_EX, rs_IF_ID, rt_IF_ID;
    logic       uses_rs_IF_ID, uses_rt_IF_ID;
    logic       md_busy, md_dep_IF_ID, branch_taken_EX, stat_clr;

    // dut a: LOAD_USE_STALLS=1, CNT_W=16; dut b: LOAD_USE_STALLS=3, CNT_W=4
    logic        a_pc, a_ifid, a_sel, a_flush;
    logic [1:0]  a_state;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifid, b_sel, b_flush;
    logic [1:0]  b_state;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .mem_read_ID_EX(mem_read_ID_EX), .rt_ID_EX(rt_ID_EX),
        .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID),
        .uses_rs_IF_ID(uses_rs_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
        .md_busy(md_busy), .md_dep_IF_ID(md_dep_IF_ID),
        .branch_taken_EX(branch_taken_EX), .stat_clr(stat_clr),
        .PC_write(a_pc), .IF_ID_write(a_ifid), .mux_ctrl_signal_sel(a_sel),
        .if_id_flush(a_flush), .stall_state(a_state), .stall_cycles(a_cnt)
    );

    hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_USE_STALLS(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_read_ID_EX(mem_read_ID_EX), .rt_ID_EX(rt_ID_EX),
        .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID),
        .uses_rs_IF_ID(uses_rs_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
        .md_busy(md_busy), .md_dep_IF_ID(md_dep_IF_ID),
        .branch_taken_EX(branch_taken_EX), .stat_clr(stat_clr),
        .PC_write(b_pc), .IF_ID_write(b_ifid), .mux_ctrl_signal_sel(b_sel),
        .if_id_flush(b_flush), .stall_state(b_state), .stall_cycles(b_cnt)
    );

    task automatic clear_inputs;
        mem_read_ID_EX  = 1'b0;
        rt_ID_EX        = 5'd0;
        rs_IF_ID        = 5'd0;
        rt_IF_ID        = 5'd0;
        uses_rs_IF_ID   = 1'b0;
        uses_rt_IF_ID   = 1'b0;
        md_busy         = 1'b0;
        md_dep_IF_ID    = 1'b0;
        branch_taken_EX = 1'b0;
        stat_clr        = 1'b0;
    endtask

    // lw r5 in EX, ID instruction reads r5 through rs
    task automatic drive_ld_haz;
        mem_read_ID_EX = 1'b1;
        rt_ID_EX       = 5'd5;
        rs_IF_ID       = 5'd5;
        uses_rs_IF_ID  = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifid, a_sel, a_flush} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 1110", {a_pc, a_ifid, a_sel, a_flush});
        end
        checks++;
        if (a_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d exp 0", a_state);
        end
        checks++;
        if (a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", a_cnt);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use_single;
        do_reset();
        drive_ld_haz();
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifid, a_sel, a_flush} !== 4'b0000) begin
            errors++;
            $display("FAIL lu1_stall got %b exp 0000", {a_pc, a_ifid, a_sel, a_flush});
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifid, a_sel, a_flush} !== 4'b1110) begin
            errors++;
            $display("FAIL lu1_release got %b exp 1110", {a_pc, a_ifid, a_sel, a_flush});
        end
        checks++;
        if (a_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu1_cnt got %0d exp 1", a_cnt);
        end
    endtask

    task automatic test_filter;
        do_reset();
        drive_ld_haz();
        rt_ID_EX = 5'd0;
        rs_IF_ID = 5'd0;
        @(negedge clk);
        checks++;
        if ({a_pc, b_pc} !== 2'b11) begin
            errors++;
            $display("FAIL filter_r0 got %b exp 11", {a_pc, b_pc});
        end
        step();
        drive_ld_haz();
        uses_rs_IF_ID = 1'b0;
        uses_rt_IF_ID = 1'b1;
        rt_IF_ID      = 5'd6;
        @(negedge clk);
        checks++;
        if ({a_pc, b_pc} !== 2'b11) begin
            errors++;
            $display("FAIL filter_unused got %b exp 11", {a_pc, b_pc});
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL filter_cnt got %0d exp 0", a_cnt);
        end
    endtask

    task automatic test_load_use_multi;
        logic       exp_pc [0:3];
        logic [1:0] exp_st [0:3];
        exp_pc = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_st = '{2'd0, 2'd1, 2'd1, 2'd0};
        do_reset();
        drive_ld_haz();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({b_pc, b_state} !== {exp_pc[i], exp_st[i]}) begin
                errors++;
                $display("FAIL lu3_cycle%0d got pc=%b st=%0d exp pc=%b st=%0d",
                         i, b_pc, b_state, exp_pc[i], exp_st[i]);
            end
            step();
            clear_inputs();
        end
        checks++;
        if (b_cnt !== 4'd3) begin
            errors++;
            $display("FAIL lu3_cnt got %0d exp 3", b_cnt);
        end
    endtask

    task automatic test_md_wait;
        do_reset();
        md_busy      = 1'b1;
        md_dep_IF_ID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({a_pc, a_sel, a_state} !== {2'b00, (i == 0) ? 2'd0 : 2'd2}) begin
                errors++;
                $display("FAIL md_stall%0d got pc=%b sel=%b st=%0d", i, a_pc, a_sel, a_state);
            end
            step();
        end
        md_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_pc, a_ifid, a_sel, a_state} !== {3'b111, 2'd2}) begin
            errors++;
            $display("FAIL md_release got %b st=%0d exp 111 st=2", {a_pc, a_ifid, a_sel}, a_state);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({a_state, a_cnt} !== {2'd0, 16'd5}) begin
            errors++;
            $display("FAIL md_after got st=%0d cnt=%0d exp st=0 cnt=5", a_state, a_cnt);
        end
    endtask

    task automatic test_branch_flush;
        do_reset();
        drive_ld_haz();
        step();
        clear_inputs();
        branch_taken_EX = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_pc, b_ifid, b_sel, b_flush, b_state} !== {4'b1101, 2'd1}) begin
            errors++;
            $display("FAIL br_flush got %b st=%0d exp 1101 st=1",
                     {b_pc, b_ifid, b_sel, b_flush}, b_state);
        end
        step();
        branch_taken_EX = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_pc, b_ifid, b_sel, b_flush, b_state} !== {4'b1110, 2'd0}) begin
            errors++;
            $display("FAIL br_after got %b st=%0d exp 1110 st=0",
                     {b_pc, b_ifid, b_sel, b_flush}, b_state);
        end
    endtask

    task automatic test_saturate_clear;
        do_reset();
        md_busy      = 1'b1;
        md_dep_IF_ID = 1'b1;
        repeat (20) step();
        @(negedge clk);
        checks++;
        if (b_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt got %0d exp 15", b_cnt);
        end
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_cnt got %0d exp 0", b_cnt);
        end
        step();
        @(negedge clk);
        checks++;
        if (b_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clr_resume got %0d exp 1", b_cnt);
        end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        drive_ld_haz();
        step();
        @(negedge clk);
        checks++;
        if (b_state !== 2'd1) begin
            errors++;
            $display("FAIL mid_pre_state got %0d exp 1", b_state);
        end
        // hazard inputs stay asserted while reset is low
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_pc, b_ifid, b_sel, b_flush, b_state} !== {4'b1110, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset got %b st=%0d exp 1110 st=0",
                     {b_pc, b_ifid, b_sel, b_flush}, b_state);
        end
        step();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use_single();
        test_filter();
        test_load_use_multi();
        test_md_wait();
        test_branch_flush();
        test_saturate_clear();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
